// File: rtl/div_ctrl.sv
// div_ctrl: sequencing controller for the iterative 32-cycle radix-2 divider.
// Owns HI/LO, accepts DIV/DIVU/MTHI/MTLO, pulses the divider start, holds its
// operands, commits quotient/remainder, stalls MFHI/MFLO while busy and
// abandons a division on pipeline flush.
// Optional feature macro: DIV_CTRL_ZERO_FAST_EN (divide-by-zero bypasses the
// divider: hi <= dividend, lo <= all ones, no busy period).
module div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [1:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        op_ready,
  input  logic        flush,
  input  logic        rd_req,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_start,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_sign,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  input  logic        div_done
);

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    RUN   = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] div_a_q, div_a_d;
  logic [31:0] div_b_q, div_b_d;
  logic        div_sign_q, div_sign_d;

  // Divide-by-zero shortcut only exists when the feature macro is defined.
  logic        zero_fast;
`ifdef DIV_CTRL_ZERO_FAST_EN
  assign zero_fast = (op_b == 32'd0);
`else
  assign zero_fast = 1'b0;
`endif

  // The divider negates its remainder whenever the live dividend has bit 31
  // set; for unsigned division that must be undone at commit time.
  logic [31:0] rem_fixed;
  assign rem_fixed = (!div_sign_q && div_a_q[31]) ? (~div_r + 32'd1) : div_r;

  // State and architectural register update, async active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      div_a_q    <= 32'd0;
      div_b_q    <= 32'd0;
      div_sign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_a_q    <= div_a_d;
      div_b_q    <= div_b_d;
      div_sign_q <= div_sign_d;
    end
  end

  // Next-state, acceptance, start pulse and commit logic.
  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_a_d    = div_a_q;
    div_b_d    = div_b_q;
    div_sign_d = div_sign_q;
    op_ready   = 1'b0;
    div_start  = 1'b0;
    case (state_q)
      IDLE: begin
        // flush has priority over an incoming op: nothing is accepted
        op_ready = ~flush;
        if (op_valid && !flush) begin
          case (op_code)
            OP_DIV, OP_DIVU: begin
              if (zero_fast) begin
                hi_d = op_a;
                lo_d = 32'hFFFF_FFFF;
              end else begin
                div_a_d    = op_a;
                div_b_d    = op_b;
                div_sign_d = (op_code == OP_DIV);
                state_d    = START;
              end
            end
            OP_MTHI: hi_d = op_a;
            OP_MTLO: lo_d = op_a;
            default: ;
          endcase
        end
      end
      START: begin
        // div_done may be stale-high from the previous op here, so ignore it
        div_start = 1'b1;
        state_d   = flush ? IDLE : RUN;
      end
      RUN: begin
        // flush beats div_done: abandon without committing
        if (flush) begin
          state_d = IDLE;
        end else if (div_done) begin
          lo_d    = div_q;
          hi_d    = rem_fixed;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign stall    = rd_req & busy;
  assign rd_data  = rd_sel ? hi_q : lo_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_a    = div_a_q;
  assign div_b    = div_b_q;
  assign div_sign = div_sign_q;

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: scoreboard bench for div_ctrl with a behavioural divider stub.
// The stimulus process pushes expected HI/LO and busy length per operation;
// a negedge monitor pops and compares when the DUT completes each operation.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic [1:0]  op_code = 2'b00;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic        op_ready;
  logic        flush = 1'b0;
  logic        rd_req = 1'b0;
  logic        rd_sel = 1'b0;
  logic [31:0] rd_data;
  logic        stall;
  logic        busy;
  logic [31:0] hi, lo;
  logic        div_start;
  logic [31:0] div_a, div_b;
  logic        div_sign;
  logic [31:0] div_q, div_r;
  logic        div_done;

  div_ctrl dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
    .op_a(op_a), .op_b(op_b), .op_ready(op_ready), .flush(flush),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_data(rd_data), .stall(stall),
    .busy(busy), .hi(hi), .lo(lo), .div_start(div_start),
    .div_a(div_a), .div_b(div_b), .div_sign(div_sign),
    .div_q(div_q), .div_r(div_r), .div_done(div_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- divider stub (no reset, done stays high until reloaded)
  logic [31:0] stub_q = 32'h5A5A_5A5A;
  logic [31:0] stub_rmag = 32'hA5A5_A5A5;
  int          stub_cnt = 0;
  logic        stub_done = 1'b1;

  function automatic logic [63:0] stub_calc(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
    logic [31:0] ma, mb, qm;
    ma = (sgn && a[31]) ? (32'd0 - a) : a;
    mb = (sgn && b[31]) ? (32'd0 - b) : b;
    if (mb == 32'd0) return {32'hFFFF_FFFF, ma};
    qm = ma / mb;
    if (sgn && (a[31] ^ b[31])) qm = 32'd0 - qm;
    return {qm, ma % mb};
  endfunction

  always @(posedge clk) begin
    if (div_start) begin
      stub_cnt  <= 32;
      stub_done <= 1'b0;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) begin
        stub_done <= 1'b1;
        {stub_q, stub_rmag} <= stub_calc(div_a, div_b, div_sign);
      end
    end
  end

  assign div_done = stub_done;
  assign div_q    = stub_q;
  assign div_r    = div_a[31] ? (32'd0 - stub_rmag) : stub_rmag;

  // ---------------- reference model and scoreboard
  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;   // stimulus-side architectural model
  bit mon_en = 1'b0;
  bit pend = 1'b0;
  bit in_txn = 1'b0;
  bit rd_rand_en = 1'b0;

`ifdef DIV_CTRL_ZERO_FAST_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  task automatic ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] rh, output logic [31:0] rl);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      rh = a;
      rl = 32'hFFFF_FFFF;
    end else if (op == 2'b01) begin
      rl = a / b;
      rh = a % b;
    end else begin
      rl = sa / sb;
      rh = sa % sb;
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int fl_n, input bit ff);
    exp_t e;
    bit got;
    if (ff) begin
      for (int i = 0; i < 300 && !(sbq.size() == 0 && !in_txn && !pend); i++)
        @(posedge clk);
    end
    e.op = op; e.a = a; e.b = b;
    if (op == 2'b10) begin
      e.hi = a; e.lo = m_lo; e.lat = 0;
    end else if (op == 2'b11) begin
      e.hi = m_hi; e.lo = a; e.lat = 0;
    end else if (ZF && b == 32'd0) begin
      e.hi = a; e.lo = 32'hFFFF_FFFF; e.lat = 0;
    end else if (fl_n >= 0) begin
      e.hi = m_hi; e.lo = m_lo; e.lat = fl_n + 1;
    end else begin
      ref_div(op, a, b, e.hi, e.lo);
      e.lat = 34;
    end
    if (ZF && op[1] == 1'b0 && b == 32'd0) fl_n = -1;
    m_hi = e.hi;
    m_lo = e.lo;
    sbq.push_back(e);
    @(posedge clk); #1;
    op_valid = 1'b1; op_code = op; op_a = a; op_b = b; flush = ff;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (op_ready) begin got = 1'b1; break; end
      @(posedge clk); #1;
      flush = 1'b0;
    end
    if (!got) begin
      $display("FAIL accept_timeout: op_ready stayed 0, expected 1 within 200 cycles");
      $fatal(1, "accept timeout");
    end
    @(posedge clk); #1;
    op_valid = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
    if (fl_n >= 0) begin
      repeat (fl_n) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
    end
  endtask

  // ---------------- monitor: one compare set per completed operation
  initial begin
    exp_t cur;
    logic [31:0] mon_hi, mon_lo;
    int bcnt, scnt;
    mon_hi = 32'd0; mon_lo = 32'd0; bcnt = 0; scnt = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (pend) begin
          pend = 1'b0;
          if (sbq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_accept: got an accept, expected none queued");
          end else begin
            cur = sbq.pop_front();
            if (cur.lat == 0) begin
              chk("single_hi", hi, cur.hi);
              chk("single_lo", lo, cur.lo);
              chk("single_busy", {31'd0, busy}, 32'd0);
              mon_hi = cur.hi; mon_lo = cur.lo;
              $display("txn op=%0d a=%h b=%h hi=%h lo=%h cycles=0", cur.op, cur.a, cur.b, hi, lo);
            end else begin
              chk("div_a", div_a, cur.a);
              chk("div_b", div_b, cur.b);
              chk("div_sign", {31'd0, div_sign}, {31'd0, (cur.op == 2'b00)});
              in_txn = 1'b1; bcnt = 0; scnt = 0;
            end
          end
        end
        if (in_txn) begin
          if (busy) begin
            bcnt++;
            if (div_start) scnt++;
            if (bcnt > 60) begin
              chk("busy_timeout", bcnt, cur.lat);
              in_txn = 1'b0;
            end
          end else begin
            chk("busy_cycles", bcnt, cur.lat);
            chk("start_pulses", scnt, 1);
            chk("commit_hi", hi, cur.hi);
            chk("commit_lo", lo, cur.lo);
            mon_hi = cur.hi; mon_lo = cur.lo;
            in_txn = 1'b0;
            $display("txn op=%0d a=%h b=%h hi=%h lo=%h cycles=%0d", cur.op, cur.a, cur.b, hi, lo, bcnt);
          end
        end
        if (!in_txn) chk("start_idle", {31'd0, div_start}, 32'd0);
        chk("op_ready", {31'd0, op_ready}, {31'd0, (!in_txn && !flush)});
        chk("stall", {31'd0, stall}, {31'd0, (rd_req && in_txn)});
        chk("rd_data", rd_data, rd_sel ? mon_hi : mon_lo);
        if (op_valid && op_ready) pend = 1'b1;
      end
    end
  end

  // Random MFHI/MFLO traffic.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rd_rand_en) begin
        rd_req = $urandom_range(0, 1);
        rd_sel = $urandom_range(0, 1);
      end
    end
  end

  // ---------------- main stimulus
  initial begin
    logic [1:0] op;
    logic [31:0] a, b;
    int fl;
    rd_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_start", {31'd0, div_start}, 32'd0);
    chk("rst_div_a", div_a, 32'd0);
    chk("rst_div_b", div_b, 32'd0);
    chk("rst_sign", {31'd0, div_sign}, 32'd0);
    chk("rst_ready", {31'd0, op_ready}, 32'd1);
    rst = 1'b0;
    rd_req = 1'b0;
    rd_rand_en = 1'b1;
    mon_en = 1'b1;

    issue(2'b01, 32'd100, 32'd7, -1, 1'b0);
    issue(2'b00, 32'hFFFF_FFF9, 32'd2, -1, 1'b0);
    issue(2'b01, 32'h8000_0001, 32'd2, -1, 1'b0);
    issue(2'b10, 32'hDEAD_BEEF, 32'd0, -1, 1'b0);
    issue(2'b11, 32'h0000_1234, 32'd0, -1, 1'b0);
    issue(2'b00, 32'hFFFF_FFF9, 32'd3, 10, 1'b0);
    issue(2'b01, 32'd5, 32'd0, -1, 1'b0);
    issue(2'b01, 32'hFFFF_FFF0, 32'd0, -1, 1'b0);
    issue(2'b00, 32'h8000_0000, 32'd0, -1, 1'b0);
    issue(2'b01, 32'd1234, 32'd5, 0, 1'b0);
    issue(2'b00, 32'd999, 32'd10, 33, 1'b0);
    issue(2'b11, 32'h0000_0055, 32'd0, -1, 1'b1);
    issue(2'b00, 32'd77, 32'hFFFF_FFF8, -1, 1'b1);

    for (int n = 0; n < 30; n++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1, 2:    b = $urandom_range(1, 15);
        3:       b = 32'd0 - $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      if (op == 2'b00 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      fl = (op[1] == 1'b0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, 33)) : -1;
      issue(op, a, b, fl, ($urandom_range(0, 6) == 0));
    end

    for (int i = 0; i < 300 && !(sbq.size() == 0 && !in_txn && !pend); i++)
      @(posedge clk);
    chk("drained", sbq.size() + int'(in_txn) + int'(pend), 0);
    mon_en = 1'b0;
    rd_rand_en = 1'b0;

    // asynchronous reset in the middle of a division
    @(posedge clk); #1;
    op_valid = 1'b1; op_code = 2'b10; op_a = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    op_code = 2'b00; op_a = 32'd100; op_b = 32'd7;
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rd_req = 1'b1;
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    chk("pre_rst_hi", hi, 32'hDEAD_BEEF);
    rst = 1'b1;
    #1;
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_stall", {31'd0, stall}, 32'd0);
    chk("arst_start", {31'd0, div_start}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    rd_req = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencing controller for the iterative 32-cycle radix-2 divider in the MIPS32 EX stage. It owns the HI/LO register pair and accepts DIV, DIVU, MTHI and MTLO from the pipeline. It pulses the divider's start, holds its operands stable, and commits quotient/remainder to LO/HI. It stalls MFHI/MFLO while a division is in flight and abandons a division on pipeline flush.

## Interface
Parameters: none.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- op_valid  in  1  EX stage presents an operation
- op_code  in  2  00 DIV, 01 DIVU, 10 MTHI, 11 MTLO
- op_a  in  32  dividend / MT source
- op_b  in  32  divisor
- op_ready  out  1  operation accepted on this edge when op_valid & op_ready
- flush  in  1  cancel in-flight division (exception/branch squash)
- rd_req  in  1  MFHI/MFLO in EX
- rd_sel  in  1  0 = LO, 1 = HI
- rd_data  out  32  combinational: rd_sel ? hi : lo
- stall  out  1  rd_req & busy
- busy  out  1  division in flight (state START or RUN)
- hi, lo  out  32  architectural HI/LO
- div_start  out  1  divider start pulse
- div_a, div_b  out  32  registered operands to divider
- div_sign  out  1  1 for DIV, 0 for DIVU
- div_q, div_r  in  32  divider quotient/remainder
- div_done  in  1  divider completion level

## Operation
- States: IDLE, START, RUN.
- IDLE: op_ready = ~flush.
  - Accepted DIV/DIVU: latch op_a/op_b into div_a/div_b, set div_sign, go to START.
  - Accepted MTHI/MTLO: write hi/lo from op_a and stay in IDLE.
- START: div_start = 1 for exactly this cycle. Next state is RUN; on flush it is IDLE.
- RUN: wait for div_done. When div_done = 1, commit and go to IDLE. On flush, go to IDLE without committing.
- Commit:
  - lo <= div_q.
  - For DIV: hi <= div_r.
  - For DIVU: hi <= div_a[31] ? (~div_r + 1) : div_r. The divider negates its remainder whenever dividend bit 31 is set, regardless of sign; this undoes that.
- div_a and div_b remain unchanged from acceptance until the next accepted DIV/DIVU. The divider's remainder correction reads its dividend live.
- div_done is ignored outside RUN. The divider has no reset, and done is stale-high from the prior op during START.
- op_ready = 0 in START and RUN. A pending op_valid must be held by the pipeline.
- Flush priority:
  - flush beats op_valid in IDLE: nothing is accepted.
  - flush beats div_done in RUN: no commit.
  - An abandoned divider may keep iterating. The next div_start reloads it.
- rd_data reflects hi/lo before the current edge. A read in the same cycle as MTHI returns the old HI.
- Reset: state IDLE; hi, lo, div_a, div_b = 0; div_sign = 0; div_start = 0; busy = 0; stall = 0.
- Reset mid-division: return to IDLE immediately; hi/lo cleared.

## Timing
- DIV accepted at edge E0.
- START occupies the cycle after E0. The divider loads at E1.
- div_done rises after E33 (32 iterations).
- RUN sees div_done in the next cycle; hi/lo are committed at E34.
- busy is high from after E0 through the cycle before E34. hi/lo are valid from E34.
- The next op can be accepted at E34 at the earliest. Issue-to-issue is 34 cycles.
- MTHI/MTLO: single cycle; value visible on hi/lo after the accepting edge.
- stall is combinational from rd_req and registered state. No cycle of rd_req is lost.

## Configuration
- Macro: DIV_CTRL_ZERO_FAST_EN.
- Defined: an accepted DIV/DIVU with op_b == 0 bypasses the divider.
  - hi <= op_a, lo <= 32'hFFFF_FFFF at the accepting edge.
  - State stays IDLE; busy never rises; div_start stays 0.
- Undefined: divide-by-zero runs the normal 34-cycle sequence and commits whatever the divider produces, after the DIVU correction.

## Test plan
- DIVU 100 / 7 issued at E0 -> busy for 34 cycles; at E34 lo = 14, hi = 2; div_start high exactly one cycle.
- DIV -7 / 2 (0xFFFFFFF9 / 2) -> lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1).
- DIVU 0x80000001 / 2 -> lo = 0x40000000, hi = 1 (correction applied); a second op presented during busy sees op_ready = 0 until E34.
- DIV in flight, rd_req = 1 with rd_sel = 1 -> stall = 1 until E34; rd_data then equals the new hi. flush at cycle 10 -> IDLE next edge, hi/lo keep their old values, stall drops.
- MTHI 0xDEADBEEF then MTLO 0x1234 on consecutive cycles -> hi/lo updated each edge with no stall; async rst asserted mid-division -> hi = lo = 0, busy = 0 without a clock edge.
- With DIV_CTRL_ZERO_FAST_EN: DIVU 5 / 0 -> next edge hi = 5, lo = 0xFFFFFFFF, busy stays 0. Without the macro -> busy for 34 cycles.
